// File: rtl/sl_receiver_block.sv
// rtl/sl_receiver_block.sv - two-line serial frame receiver; optional SL_RX_GLITCH_FILTER_EN low-level filter
module sl_receiver_block (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_line_zeroes_a,
    input  logic        serial_line_ones_a,
    input  logic        wr_enable,
    input  logic [15:0] wr_config_w,
    output logic [15:0] r_config_w,
    output logic [31:0] data_w,
    output logic [15:0] status_w,
    output logic        data_status_changed
);

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_APPLY,
        PS_HOLD
    } pulse_state_t;

    logic        z_s1, z_s2, o_s1, o_s2;
    logic        low_z, low_o;
    logic        in_sym, saw_z, saw_o, saw_both;
    logic        skip_sym;
    logic [5:0]  sym_cnt;
    logic [31:0] bits;
    logic        ones_par;
    logic [6:0]  cfg;
    logic        cfg_unused;

    logic        sym_end;
    logic        accept;
    logic        frame_end;
    logic [5:0]  cfg_n;
    logic        lerr_c, perr_c;
    logic [31:0] mask_c;

    pulse_state_t pstate;
    logic [15:0]  pend_status;
    logic [31:0]  pend_data;
    logic         pend_ok;

    assign cfg_unused = ^wr_config_w[15:7];
    assign r_config_w = {9'd0, cfg};
    assign cfg_n      = cfg[6:1];

    // Two-flop synchronizers, idle-high so reset parks them at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            z_s1 <= 1'b1;
            z_s2 <= 1'b1;
            o_s1 <= 1'b1;
            o_s2 <= 1'b1;
        end else begin
            z_s1 <= serial_line_zeroes_a;
            z_s2 <= z_s1;
            o_s1 <= serial_line_ones_a;
            o_s2 <= o_s1;
        end
    end

`ifdef SL_RX_GLITCH_FILTER_EN
    logic [2:0] fz_cnt, fo_cnt;

    // Count consecutive synced low samples per line, saturating at 4
    always_ff @(posedge clk) begin
        if (rst) begin
            fz_cnt <= 3'd0;
            fo_cnt <= 3'd0;
        end else begin
            fz_cnt <= z_s2 ? 3'd0 : ((fz_cnt == 3'd4) ? 3'd4 : fz_cnt + 3'd1);
            fo_cnt <= o_s2 ? 3'd0 : ((fo_cnt == 3'd4) ? 3'd4 : fo_cnt + 3'd1);
        end
    end

    assign low_z = (fz_cnt == 3'd4);
    assign low_o = (fo_cnt == 3'd4);
`else
    assign low_z = ~z_s2;
    assign low_o = ~o_s2;
`endif

    // Symbol end, frame end and the result of the frame being closed
    always_comb begin
        sym_end   = in_sym && !low_z && !low_o;
        accept    = sym_end && !skip_sym && !wr_enable;
        frame_end = accept && saw_both;
        lerr_c    = (sym_cnt < 6'd2) || ((sym_cnt - 6'd1) != cfg_n);
        perr_c    = cfg[0] && !lerr_c && !ones_par;
        mask_c    = (cfg_n >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_n) - 32'd1);
    end

    // Track one low interval and remember which lines were low in it
    always_ff @(posedge clk) begin
        if (rst) begin
            in_sym   <= 1'b0;
            saw_z    <= 1'b0;
            saw_o    <= 1'b0;
            saw_both <= 1'b0;
        end else if (low_z || low_o) begin
            in_sym   <= 1'b1;
            saw_z    <= saw_z | low_z;
            saw_o    <= saw_o | low_o;
            saw_both <= saw_both | (low_z & low_o);
        end else if (in_sym) begin
            in_sym   <= 1'b0;
            saw_z    <= 1'b0;
            saw_o    <= 1'b0;
            saw_both <= 1'b0;
        end
    end

    // Config register and frame accumulation; a write throws away the open frame
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg      <= 7'h10;
            sym_cnt  <= 6'd0;
            bits     <= 32'd0;
            ones_par <= 1'b0;
            skip_sym <= 1'b0;
        end else if (wr_enable) begin
            cfg      <= wr_config_w[6:0];
            sym_cnt  <= 6'd0;
            bits     <= 32'd0;
            ones_par <= 1'b0;
            skip_sym <= in_sym && !sym_end;
        end else if (sym_end) begin
            skip_sym <= 1'b0;
            if (accept) begin
                if (saw_both) begin
                    sym_cnt  <= 6'd0;
                    bits     <= 32'd0;
                    ones_par <= 1'b0;
                end else begin
                    if (sym_cnt < 6'd32) begin
                        bits[sym_cnt[4:0]] <= saw_o;
                    end
                    if (sym_cnt != 6'd63) begin
                        sym_cnt <= sym_cnt + 6'd1;
                    end
                    ones_par <= ones_par ^ saw_o;
                end
            end
        end
    end

    // Completion pulse sequencer: capture result, publish it after the first pulse cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pstate              <= PS_IDLE;
            data_status_changed <= 1'b0;
            data_w              <= 32'd0;
            status_w            <= 16'd0;
            pend_status         <= 16'd0;
            pend_data           <= 32'd0;
            pend_ok             <= 1'b0;
        end else begin
            case (pstate)
                PS_IDLE: begin
                    if (frame_end) begin
                        pend_status         <= {11'd0, perr_c, 1'b1, 2'b00, lerr_c};
                        pend_data           <= bits & mask_c;
                        pend_ok             <= !lerr_c && !perr_c;
                        data_status_changed <= 1'b1;
                        pstate              <= PS_APPLY;
                    end
                end
                PS_APPLY: begin
                    status_w <= pend_status;
                    if (pend_ok) begin
                        data_w <= pend_data;
                    end
                    pstate <= PS_HOLD;
                end
                PS_HOLD: begin
                    data_status_changed <= 1'b0;
                    pstate              <= PS_IDLE;
                end
                default: begin
                    data_status_changed <= 1'b0;
                    pstate              <= PS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sl_receiver_block.sv
// tb/tb_sl_receiver_block.sv - scoreboard bench for sl_receiver_block
module tb_sl_receiver_block;

    logic        clk = 1'b0;
    logic        rst;
    logic        zl, ol;
    logic        wr_enable;
    logic [15:0] wr_config_w;
    logic [15:0] r_config_w;
    logic [31:0] data_w;
    logic [15:0] status_w;
    logic        data_status_changed;

    sl_receiver_block dut (
        .clk                  (clk),
        .rst                  (rst),
        .serial_line_zeroes_a (zl),
        .serial_line_ones_a   (ol),
        .wr_enable            (wr_enable),
        .wr_config_w          (wr_config_w),
        .r_config_w           (r_config_w),
        .data_w               (data_w),
        .status_w             (status_w),
        .data_status_changed  (data_status_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] status;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulse_count = 0;
    logic [31:0] model_data = 32'd0;
    int          cfg_n = 8;
    bit          cfg_pce = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic send_sym(input int kind);
        @(posedge clk); #2;
        if (kind != 1) zl = 1'b0;
        if (kind != 0) ol = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        zl = 1'b1;
        ol = 1'b1;
        repeat (16) @(posedge clk);
    endtask

    task automatic write_cfg(input logic [15:0] v);
        @(posedge clk); #2;
        wr_enable   = 1'b1;
        wr_config_w = v;
        @(posedge clk); #2;
        wr_enable = 1'b0;
        cfg_n     = int'(v[6:1]);
        cfg_pce   = v[0];
    endtask

    // Reference model: count data bits and ones, then apply the frame rules
    task automatic send_frame(input logic [63:0] fbits, input int nd, input bit flip_par);
        int   ones;
        bit   par, lerr, perr;
        exp_t e;
        ones = 0;
        for (int i = 0; i < nd; i++) ones += int'(fbits[i]);
        par = (ones % 2 == 0);
        if (flip_par) par = !par;
        lerr = (nd + 1 < 2) || (nd != cfg_n);
        perr = cfg_pce && !lerr && ((ones + int'(par)) % 2 == 0);
        if (!lerr && !perr) begin
            model_data = 32'd0;
            for (int i = 0; i < cfg_n && i < 32; i++) model_data[i] = fbits[i];
        end
        e.status = 16'd0;
        e.status[4] = perr;
        e.status[3] = 1'b1;
        e.status[0] = lerr;
        e.data = model_data;
        exp_q.push_back(e);
        for (int i = 0; i < nd; i++) send_sym(int'(fbits[i]));
        send_sym(int'(par));
        send_sym(2);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: every pulse must be expected, last 2 cycles, and carry the predicted result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_status_changed === 1'b1) begin
                pulse_count++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got pulse expected none");
                    @(negedge clk);
                    @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    check("pulse_cycle2", {31'd0, data_status_changed}, 32'd1);
                    check("status_w", {16'd0, status_w}, {16'd0, e.status});
                    check("data_w", data_w, e.data);
                    @(negedge clk);
                    check("pulse_end", {31'd0, data_status_changed}, 32'd0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout: got no finish expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [63:0] r;
        int          pc;
        int          nd;
        logic [15:0] c;
        rst = 1'b1;
        zl = 1'b1;
        ol = 1'b1;
        wr_enable = 1'b0;
        wr_config_w = 16'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_cfg", {16'd0, r_config_w}, 32'h0010);
        check("rst_data", data_w, 32'd0);
        check("rst_status", {16'd0, status_w}, 32'd0);
        check("rst_pulse", {31'd0, data_status_changed}, 32'd0);

        write_cfg(16'h0028);
        send_frame(64'h5A3C1, 20, 1'b0);
        drain("drain_basic");
        write_cfg(16'h0029);
        r = {$urandom, $urandom};
        send_frame(r, 20, 1'b0);
        send_frame({$urandom, $urandom}, 22, 1'b0);
        send_frame({$urandom, $urandom}, 20, 1'b0);
        send_frame({$urandom, $urandom}, 18, 1'b0);
        send_frame({$urandom, $urandom}, 20, 1'b1);
        write_cfg(16'h0028);
        send_frame({$urandom, $urandom}, 20, 1'b1);
        drain("drain_directed");

        write_cfg(16'h0041);
        @(negedge clk);
        check("cfg_readback", {16'd0, r_config_w}, 32'h0041);
        write_cfg(16'hFFC3);
        @(negedge clk);
        check("cfg_upper_zero", {16'd0, r_config_w}, 32'h0043);

        for (int k = 0; k < 12; k++) begin
            c = 16'd0;
            c[6:1] = 6'($urandom_range(1, 32));
            c[0] = 1'($urandom_range(0, 1));
            write_cfg(c);
            nd = cfg_n;
            if ($urandom_range(0, 3) == 0) nd = cfg_n + $urandom_range(1, 3);
            else if ($urandom_range(0, 3) == 0) nd = (cfg_n > 2) ? cfg_n - 2 : 0;
            send_frame({$urandom, $urandom}, nd, ($urandom_range(0, 3) == 0));
        end
        drain("drain_random");

        write_cfg(16'h0028);
        for (int i = 0; i < 5; i++) send_sym(int'($urandom_range(0, 1)));
        pc = pulse_count;
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_data = 32'd0;
        cfg_n = 8;
        cfg_pce = 1'b0;
        @(negedge clk);
        check("midrst_data", data_w, 32'd0);
        check("midrst_status", {16'd0, status_w}, 32'd0);
        check("midrst_cfg", {16'd0, r_config_w}, 32'h0010);
        check("midrst_pulse", {31'd0, data_status_changed}, 32'd0);
        repeat (100) @(posedge clk);
        check("midrst_no_pulse", pulse_count, pc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
